// File: rtl/sdram_sched_pkg.sv
// Shared types for the SDRAM port scheduler: state encoding, address-word field layout, burst length decode.
// Pure definitions, no clocked logic.
package sdram_sched_pkg;

  typedef enum logic [3:0] {
    IDLE, ADR, CAP, CMD, WPOP, WCAP, WVAL, RDAT, DONE
  } state_t;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;
  localparam logic [2:0] CTI_CLASSIC = 3'b000;

  localparam int WE_I   = 5;
  localparam int BTE_HI = 4;
  localparam int BTE_LO = 3;
  localparam int CTI_HI = 2;
  localparam int CTI_LO = 0;
  localparam int ADR_HI = 35;
  localparam int ADR_LO = 6;

  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Classic cycles are always single-word, whatever bte says.
  function automatic logic [4:0] burst_len(input logic [1:0] bte, input logic [2:0] cti);
    logic [4:0] len;
    len = 5'd1;
    if (cti != CTI_CLASSIC) begin
      case (bte)
        BTE_LINEAR: len = 5'd1;
        BTE_WRAP4:  len = 5'd4;
        BTE_WRAP8:  len = 5'd8;
        BTE_WRAP16: len = 5'd16;
        default:    len = 5'd1;
      endcase
    end
    return len;
  endfunction

endpackage

// File: rtl/sdram_port_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr_i, wrapping N-1 -> 0.
// Zero latency; no backpressure of its own.
module rr_arbiter
  import sdram_sched_pkg::*;
#(
  parameter int nr_of_wb_ports = 3,
  parameter int IW             = idx_bits(nr_of_wb_ports)
) (
  input  logic [nr_of_wb_ports-1:0] req_i,
  input  logic [IW-1:0]             ptr_i,
  output logic [nr_of_wb_ports-1:0] gnt_o,
  output logic [IW-1:0]             gnt_idx_o,
  output logic                      any_req_o
);

  always_comb begin
    int   idx;
    logic found;
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    for (int k = 0; k < nr_of_wb_ports; k++) begin
      idx = (int'(ptr_i) + k) % nr_of_wb_ports;
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = IW'(idx);
      end
    end
  end

  assign any_req_o = |req_i;

endmodule

// File: rtl/sdram_port_sched.sv
// Shares egress/ingress FIFOs between wishbone ports: one request at a time, address pop -> command -> data.
// Grant to command is 3 cycles; cmd_ready, wr_ready and an empty egress queue each stall the FSM in place.
module sdram_port_sched
  import sdram_sched_pkg::*;
#(
  parameter int nr_of_wb_ports = 3
) (
  input  logic                      sdram_clk,
  input  logic                      sdram_rst,
  input  logic [0:nr_of_wb_ports-1] fifo_empty,
  input  logic [0:nr_of_wb_ports-1] fifo_flag,
  input  logic [35:0]               fifo_q,
  output logic [0:nr_of_wb_ports-1] fifo_re,
  output logic                      fifo_rd_adr,
  output logic                      fifo_rd_data,
  output logic                      ingress_wr,
  output logic [0:nr_of_wb_ports-1] ingress_we,
  output logic                      burst_reading,
  output logic                      cmd_valid,
  input  logic                      cmd_ready,
  output logic                      cmd_we,
  output logic [29:0]               cmd_adr,
  output logic [4:0]                cmd_len,
  output logic                      wr_valid,
  input  logic                      wr_ready,
  output logic [31:0]               wr_dat,
  output logic [3:0]                wr_sel,
  input  logic                      rd_valid
);

  localparam int N  = nr_of_wb_ports;
  localparam int IW = idx_bits(N);

  state_t          state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [N-1:0]    owner_oh_q, owner_oh_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [29:0]     cmd_adr_q, cmd_adr_d;
  logic            cmd_we_q, cmd_we_d;
  logic [4:0]      cmd_len_q, cmd_len_d;
  logic [31:0]     wr_dat_q, wr_dat_d;
  logic [3:0]      wr_sel_q, wr_sel_d;

  logic [N-1:0]    req;
  logic [N-1:0]    gnt;
  logic [IW-1:0]   gnt_idx;
  logic            any_req;
  logic            owner_empty;

  always_comb begin
    req = '0;
    for (int i = 0; i < N; i++) req[i] = fifo_flag[i] & ~fifo_empty[i];
  end

  assign owner_empty = fifo_empty[owner_q];

  rr_arbiter #(
    .nr_of_wb_ports(N),
    .IW            (IW)
  ) u_arb (
    .req_i    (req),
    .ptr_i    (rr_q),
    .gnt_o    (gnt),
    .gnt_idx_o(gnt_idx),
    .any_req_o(any_req)
  );

  always_ff @(posedge sdram_clk or posedge sdram_rst) begin
    if (sdram_rst) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      owner_oh_q <= '0;
      rr_q       <= '0;
      cnt_q      <= '0;
      cmd_adr_q  <= '0;
      cmd_we_q   <= 1'b0;
      cmd_len_q  <= '0;
      wr_dat_q   <= '0;
      wr_sel_q   <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      owner_oh_q <= owner_oh_d;
      rr_q       <= rr_d;
      cnt_q      <= cnt_d;
      cmd_adr_q  <= cmd_adr_d;
      cmd_we_q   <= cmd_we_d;
      cmd_len_q  <= cmd_len_d;
      wr_dat_q   <= wr_dat_d;
      wr_sel_q   <= wr_sel_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    owner_oh_d = owner_oh_q;
    rr_d       = rr_q;
    cnt_d      = cnt_q;
    cmd_adr_d  = cmd_adr_q;
    cmd_we_d   = cmd_we_q;
    cmd_len_d  = cmd_len_q;
    wr_dat_d   = wr_dat_q;
    wr_sel_d   = wr_sel_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          owner_d    = gnt_idx;
          owner_oh_d = gnt;
          state_d    = ADR;
        end
      end
      ADR:  state_d = CAP;
      // fifo_q now holds the address word popped in ADR.
      CAP: begin
        cmd_adr_d = fifo_q[ADR_HI:ADR_LO];
        cmd_we_d  = fifo_q[WE_I];
        cmd_len_d = burst_len(fifo_q[BTE_HI:BTE_LO], fifo_q[CTI_HI:CTI_LO]);
        state_d   = CMD;
      end
      CMD: begin
        if (cmd_ready) begin
          cnt_d   = cmd_len_q;
          state_d = cmd_we_q ? WPOP : RDAT;
        end
      end
      WPOP: begin
        if (!owner_empty) state_d = WCAP;
      end
      WCAP: begin
        wr_dat_d = fifo_q[35:4];
        wr_sel_d = fifo_q[3:0];
        state_d  = WVAL;
      end
      WVAL: begin
        if (wr_ready) begin
          cnt_d   = cnt_q - 5'd1;
          state_d = (cnt_q == 5'd1) ? DONE : WPOP;
        end
      end
      RDAT: begin
        if (rd_valid) begin
          cnt_d = cnt_q - 5'd1;
          if (cnt_q == 5'd1) state_d = DONE;
        end
      end
      DONE: begin
        rr_d    = (owner_q == IW'(N - 1)) ? '0 : owner_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fifo_rd_adr   = (state_q == ADR);
    fifo_rd_data  = (state_q == WPOP) && !owner_empty;
    ingress_wr    = (state_q == RDAT) && rd_valid;
    burst_reading = (state_q == RDAT);
    cmd_valid     = (state_q == CMD);
    wr_valid      = (state_q == WVAL);
    fifo_re       = '0;
    ingress_we    = '0;
    for (int i = 0; i < N; i++) begin
      fifo_re[i]    = (fifo_rd_adr | fifo_rd_data) & owner_oh_q[i];
      ingress_we[i] = ingress_wr & owner_oh_q[i];
    end
  end

  assign cmd_we  = cmd_we_q;
  assign cmd_adr = cmd_adr_q;
  assign cmd_len = cmd_len_q;
  assign wr_dat  = wr_dat_q;
  assign wr_sel  = wr_sel_q;

endmodule

// File: tb/tb_sdram_port_sched.sv
// Directed bench for sdram_port_sched with a behavioural multi-queue egress FIFO.
module tb_sdram_port_sched;

  localparam int N = 3;

  logic           sdram_clk = 1'b0;
  logic           sdram_rst;
  logic [0:N-1]   fifo_empty, fifo_flag, fifo_re, ingress_we;
  logic [35:0]    fifo_q;
  logic           fifo_rd_adr, fifo_rd_data, ingress_wr, burst_reading;
  logic           cmd_valid, cmd_ready, cmd_we, wr_valid, wr_ready, rd_valid;
  logic [29:0]    cmd_adr;
  logic [4:0]     cmd_len;
  logic [31:0]    wr_dat;
  logic [3:0]     wr_sel;

  int tests = 0;
  int fails = 0;

  sdram_port_sched #(.nr_of_wb_ports(N)) dut (
    .sdram_clk    (sdram_clk),
    .sdram_rst    (sdram_rst),
    .fifo_empty   (fifo_empty),
    .fifo_flag    (fifo_flag),
    .fifo_q       (fifo_q),
    .fifo_re      (fifo_re),
    .fifo_rd_adr  (fifo_rd_adr),
    .fifo_rd_data (fifo_rd_data),
    .ingress_wr   (ingress_wr),
    .ingress_we   (ingress_we),
    .burst_reading(burst_reading),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_we       (cmd_we),
    .cmd_adr      (cmd_adr),
    .cmd_len      (cmd_len),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_dat       (wr_dat),
    .wr_sel       (wr_sel),
    .rd_valid     (rd_valid)
  );

  always #5 sdram_clk = ~sdram_clk;

  // Egress FIFO model: registered output, word appears the cycle after the pop.
  logic [35:0] mem [N][32];
  int          rd_ptr [N];
  int          wr_ptr [N];
  logic [0:N-1] flag_en, force_empty;

  always @(posedge sdram_clk or posedge sdram_rst) begin
    if (sdram_rst) begin
      fifo_q <= '0;
      for (int i = 0; i < N; i++) rd_ptr[i] <= 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (fifo_re[i] && (fifo_rd_adr || fifo_rd_data)) begin
          fifo_q    <= mem[i][rd_ptr[i] % 32];
          rd_ptr[i] <= rd_ptr[i] + 1;
        end
      end
    end
  end

  always_comb begin
    fifo_empty = '0;
    fifo_flag  = '0;
    for (int i = 0; i < N; i++) begin
      fifo_empty[i] = force_empty[i] | (rd_ptr[i] == wr_ptr[i]);
      fifo_flag[i]  = flag_en[i] & (rd_ptr[i] != wr_ptr[i]);
    end
  end

  // Event logs and protocol-violation tallies, inspected from the main sequence.
  logic [35:0]  wr_log [$];
  logic [0:N-1] ing_log [$];
  logic [0:N-1] grant_log [$];
  int n_pop = 0;
  int bad_popctl = 0;
  int bad_popempty = 0;
  int bad_ing = 0;

  always @(negedge sdram_clk) begin
    if (!sdram_rst) begin
      if ($countones(fifo_re) > 1 || (fifo_rd_adr && fifo_rd_data) ||
          ((fifo_re != '0) != (fifo_rd_adr || fifo_rd_data)))
        bad_popctl++;
      if (fifo_rd_data && ((fifo_re & fifo_empty) != '0)) bad_popempty++;
      if (ingress_wr && !burst_reading) bad_ing++;
      if (fifo_rd_data) n_pop++;
      if (fifo_rd_adr) grant_log.push_back(fifo_re);
      if (wr_valid && wr_ready) wr_log.push_back({wr_dat, wr_sel});
      if (ingress_wr) ing_log.push_back(ingress_we);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sdram_clk);
    #1;
  endtask

  task automatic neg();
    @(negedge sdram_clk);
  endtask

  task automatic wait_cmd();
    int i;
    i = 0;
    while (!cmd_valid && i < 100) begin step(); i++; end
    chk("cmd_valid_timeout", 64'(cmd_valid), 64'd1);
  endtask

  task automatic wait_wr();
    int i;
    i = 0;
    while (!wr_valid && i < 100) begin step(); i++; end
    chk("wr_valid_timeout", 64'(wr_valid), 64'd1);
  endtask

  task automatic push(input int p, input logic [35:0] w);
    mem[p][wr_ptr[p] % 32] = w;
    wr_ptr[p]++;
  endtask

  function automatic logic [35:0] aw(input logic [29:0] a, input logic we,
                                     input logic [1:0] bte, input logic [2:0] cti);
    return {a, we, bte, cti};
  endfunction

  function automatic logic [35:0] dw(input int k);
    return {32'hA5A5_0000 | 32'(k), 4'(k) ^ 4'hF};
  endfunction

  function automatic logic [0:N-1] oh(input int p);
    logic [0:N-1] v;
    v = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  function automatic logic [47:0] ctl_vec();
    return {fifo_re, fifo_rd_adr, fifo_rd_data, ingress_wr, ingress_we, burst_reading,
            cmd_valid, cmd_we, cmd_adr, cmd_len, wr_valid};
  endfunction

  initial begin
    int base, bad, pop0;
    logic [35:0] e;

    sdram_rst = 1'b1;
    cmd_ready = 1'b0;
    wr_ready  = 1'b0;
    rd_valid  = 1'b0;
    flag_en     = '0;
    force_empty = '0;
    for (int i = 0; i < N; i++) wr_ptr[i] = 0;
    repeat (3) step();
    neg();
    chk("reset_ctl", 64'(ctl_vec()), 64'd0);
    chk("reset_wr", 64'({wr_dat, wr_sel}), 64'd0);
    step();
    sdram_rst = 1'b0;

    // Spurious read data while idle
    step();
    rd_valid = 1'b1;
    neg();
    chk("spur_idle_ing", 64'(ingress_wr), 64'd0);
    step();
    rd_valid = 1'b0;

    // Single wrap4 read on port 1
    push(1, aw(30'h1000, 1'b0, 2'b01, 3'b010));
    flag_en[1] = 1'b1;
    wait_cmd();
    neg();
    chk("t1_adr", 64'(cmd_adr), 64'h1000);
    chk("t1_len", 64'(cmd_len), 64'd4);
    chk("t1_we", 64'(cmd_we), 64'd0);
    chk("t1_grant", 64'(grant_log[grant_log.size()-1]), 64'(oh(1)));
    step();
    rd_valid = 1'b1;
    neg();
    chk("spur_cmd_ing", 64'(ingress_wr), 64'd0);
    chk("cmd_hold", 64'(cmd_valid), 64'd1);
    step();
    rd_valid  = 1'b0;
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    base = ing_log.size();
    for (int k = 0; k < 4; k++) begin
      rd_valid = 1'b1;
      neg();
      chk("t1_burst_on", 64'(burst_reading), 64'd1);
      step();
      rd_valid = 1'b0;
      neg();
      chk("t1_burst_gap", 64'(burst_reading), 64'(k < 3));
      step();
    end
    chk("t1_ing_count", 64'(ing_log.size() - base), 64'd4);
    bad = 0;
    for (int k = base; k < ing_log.size(); k++) if (ing_log[k] !== oh(1)) bad++;
    chk("t1_ing_we", 64'(bad), 64'd0);

    // Ports 0 and 2 together: pointer sits at 2; port 2 is classic with bte=wrap16
    push(0, aw(30'h111, 1'b0, 2'b00, 3'b010));
    push(2, aw(30'h222, 1'b0, 2'b11, 3'b000));
    flag_en[0] = 1'b1;
    flag_en[2] = 1'b1;
    wait_cmd();
    neg();
    chk("t4_adr", 64'(cmd_adr), 64'h222);
    chk("t4_len", 64'(cmd_len), 64'd1);
    chk("t4_grant", 64'(grant_log[grant_log.size()-1]), 64'(oh(2)));
    step();
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    rd_valid  = 1'b1;
    neg();
    chk("t4_ing_wr", 64'(ingress_wr), 64'd1);
    chk("t4_ing_we", 64'(ingress_we), 64'(oh(2)));
    step();
    neg();
    chk("t4_single_ing", 64'(ingress_wr), 64'd0);
    step();
    rd_valid = 1'b0;
    wait_cmd();
    neg();
    chk("t4b_adr", 64'(cmd_adr), 64'h111);
    chk("t4b_len", 64'(cmd_len), 64'd1);
    step();
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    rd_valid  = 1'b1;
    neg();
    chk("t4b_ing_we", 64'(ingress_we), 64'(oh(0)));
    step();
    rd_valid = 1'b0;

    // Wrap8 write on port 0 with wr_ready and empty-queue stalls
    push(0, aw(30'h2A0, 1'b1, 2'b10, 3'b010));
    for (int k = 0; k < 8; k++) push(0, dw(k));
    pop0 = n_pop;
    base = wr_log.size();
    wait_cmd();
    neg();
    chk("t2_we", 64'(cmd_we), 64'd1);
    chk("t2_len", 64'(cmd_len), 64'd8);
    chk("t2_adr", 64'(cmd_adr), 64'h2A0);
    step();
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    for (int w = 0; w < 8; w++) begin
      wait_wr();
      e = dw(w);
      repeat (3) begin
        neg();
        chk("t2_wr_hold", 64'({wr_valid, wr_dat, wr_sel}), 64'({1'b1, e}));
        step();
      end
      wr_ready = 1'b1;
      if (w == 3) force_empty[0] = 1'b1;
      step();
      wr_ready = 1'b0;
      if (w == 3) begin
        neg();
        chk("t2_stall_pop", 64'(fifo_rd_data), 64'd0);
        step();
        neg();
        chk("t2_stall_pop", 64'(fifo_rd_data), 64'd0);
        step();
        force_empty[0] = 1'b0;
      end
    end
    step();
    chk("t2_hs_count", 64'(wr_log.size() - base), 64'd8);
    bad = 0;
    for (int k = 0; k < 8; k++) if (wr_log[base + k] !== dw(k)) bad++;
    chk("t2_data_order", 64'(bad), 64'd0);
    chk("t2_pop_count", 64'(n_pop - pop0), 64'd8);
    chk("t2_pop_empty", 64'(bad_popempty), 64'd0);

    // Wrap16 write on port 1 cut by reset after 3 words
    push(1, aw(30'h3000, 1'b1, 2'b11, 3'b010));
    for (int k = 0; k < 16; k++) push(1, dw(16 + k));
    base = wr_log.size();
    wait_cmd();
    neg();
    chk("t6_len", 64'(cmd_len), 64'd16);
    step();
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    for (int w = 0; w < 3; w++) begin
      wait_wr();
      wr_ready = 1'b1;
      step();
      wr_ready = 1'b0;
    end
    wait_wr();
    chk("t6_hs_before", 64'(wr_log.size() - base), 64'd3);
    sdram_rst = 1'b1;
    #1;
    chk("t6_async_ctl", 64'(ctl_vec()), 64'd0);
    chk("t6_async_wr", 64'({wr_dat, wr_sel}), 64'd0);
    for (int i = 0; i < N; i++) wr_ptr[i] = 0;
    step();
    step();
    sdram_rst = 1'b0;
    neg();
    chk("t6_post_idle", 64'(cmd_valid), 64'd0);

    // Round-robin from pointer 0 with all ports holding classic reads
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < N; p++) push(p, aw(30'(p * 16 + k), 1'b0, 2'b00, 3'b000));
    flag_en = '1;
    for (int g = 0; g < 6; g++) begin
      wait_cmd();
      neg();
      chk("t3_order", 64'(cmd_adr), 64'((g % 3) * 16 + g / 3));
      chk("t3_len", 64'(cmd_len), 64'd1);
      step();
      cmd_ready = 1'b1;
      step();
      cmd_ready = 1'b0;
      rd_valid  = 1'b1;
      neg();
      chk("t3_ing_we", 64'(ingress_we), 64'(oh(g % 3)));
      step();
      rd_valid = 1'b0;
    end

    chk("pop_ctrl", 64'(bad_popctl), 64'd0);
    chk("pop_empty", 64'(bad_popempty), 64'd0);
    chk("ing_outside", 64'(bad_ing), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
